// File: rtl/alu_mdu.sv
// Combinational ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
// Define ALU_MDU_DIV_EN to build the divider; without it divide opcodes are no-ops.
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             Equal,
    input  logic [2:0]       MDOp,
    input  logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SHW    = $clog2(WIDTH);
    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    logic [SHW-1:0]     sh;
    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa, opb;
    logic               op_signed;
    logic               accept;
    logic               done;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign sh = B[SHW-1:0];

    always_comb begin
        C = '0;
        case (ALUOp)
            4'b0000: C = A + B;
            4'b0001: C = A - B;
            4'b0010: C = A & B;
            4'b0011: C = A | B;
            4'b0100: C = A >> sh;
            4'b0101: C = $signed(A) >>> sh;
            4'b0110: C = A << sh;
            4'b0111: C = A ^ B;
            4'b1000: C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1001: C = {{(WIDTH-1){1'b0}}, (A < B)};
            default: C = '0;
        endcase
    end

    assign Equal  = (A == B);

    assign Busy   = (state != IDLE);
    assign accept = (state == IDLE) && Start;
    assign done   = ((state == MUL) && (cnt == CW'(MUL_LAT))) ||
                    ((state == DIV) && (cnt == CW'(DIV_LAT)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        3'b000, 3'b001: state_nxt = MUL;
`ifdef ALU_MDU_DIV_EN
                        3'b010, 3'b011: state_nxt = DIV;
`endif
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            MUL, DIV: if (done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operands are captured at acceptance so later input changes cannot disturb the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            op_signed <= 1'b0;
        end else begin
            if (state == IDLE) cnt <= CW'(1);
            else               cnt <= cnt + CW'(1);
            if (accept) begin
                opa       <= A;
                opb       <= B;
                op_signed <= ~MDOp[0];
            end
        end
    end

    // One double-width multiplier serves both signednesses via the extension bit.
    assign ext_a = {{WIDTH{op_signed & opa[WIDTH-1]}}, opa};
    assign ext_b = {{WIDTH{op_signed & opb[WIDTH-1]}}, opb};
    assign prod  = ext_a * ext_b;

`ifdef ALU_MDU_DIV_EN
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] ua, ub, uq, ur, quo, rem;

    // Sign-magnitude divide; most-negative / -1 falls out as quotient = most-negative.
    always_comb begin
        a_neg = op_signed & opa[WIDTH-1];
        b_neg = op_signed & opb[WIDTH-1];
        ua    = a_neg ? -opa : opa;
        ub    = b_neg ? -opb : opb;
        uq    = '0;
        ur    = '0;
        quo   = '1;
        rem   = opa;
        if (opb != '0) begin
            uq  = ua / ub;
            ur  = ua % ub;
            quo = (a_neg ^ b_neg) ? -uq : uq;
            rem = a_neg ? -ur : ur;
        end
    end
`endif

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        if (state == DIV) begin
            res_hi = rem;
            res_lo = quo;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (accept && (MDOp == 3'b100)) begin
            HI <= A;
        end else if (accept && (MDOp == 3'b101)) begin
            LO <= A;
        end else if (done) begin
            HI <= res_hi;
            LO <= res_lo;
        end
    end

endmodule
